// File: rtl/systolic_result_drain.sv
// ---------------------------------------------------------------------------
// systolic_result_drain
//
// Output stage of the systolic matrix multiplier. When the MAC grid pulses
// acc_valid, the whole N*N accumulator array is copied into a local snapshot
// so the grid can be cleared and reloaded immediately. The snapshot is then
// requantized (arithmetic right shift + saturation to OUT_WIDTH) and streamed
// row-major over a valid/ready interface, one element per beat.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   acc_in     N*N signed accumulators, element (r,c) at ACC_WIDTH*(r*N+c)
//   acc_valid  single-cycle pulse: acc_in is complete this cycle
//   shift      right-shift amount, sampled together with acc_valid
//   busy       a snapshot is held and not yet fully drained
//   out_data   requantized element (signed)
//   out_row    row index of out_data
//   out_col    column index of out_data
//   out_last   out_data is element (N-1,N-1)
//   out_valid  out_data/out_row/out_col/out_last are valid
//   out_ready  consumer accepts the beat when out_valid is also high
//   sat_flag   some element of the current matrix saturated (sticky until
//              the next capture)
//   dropped    sticky: a capture request arrived while busy and was lost
// ---------------------------------------------------------------------------
module systolic_result_drain #(
    parameter int N           = 2,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int LOG2_MAX_N  = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N*N*ACC_WIDTH-1:0]     acc_in,
    input  logic                         acc_valid,
    input  logic [SHIFT_WIDTH-1:0]       shift,
    output logic                         busy,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic [LOG2_MAX_N-1:0]        out_row,
    output logic [LOG2_MAX_N-1:0]        out_col,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         sat_flag,
    output logic                         dropped
);

    localparam int ELEMS = N * N;
    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [LOG2_MAX_N-1:0] LAST_RC = LOG2_MAX_N'(N - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                      state_reg;
    logic signed [ACC_WIDTH-1:0] acc_arr  [ELEMS];
    logic signed [ACC_WIDTH-1:0] snap_reg [ELEMS];
    logic [SHIFT_WIDTH-1:0]      shift_reg;
    logic [IDX_W-1:0]            elem_reg;
    logic [LOG2_MAX_N-1:0]       row_reg;
    logic [LOG2_MAX_N-1:0]       col_reg;
    logic [OUT_WIDTH-1:0]        out_data_reg;
    logic                        out_last_reg;
    logic                        out_valid_reg;
    logic                        busy_reg;
    logic                        sat_reg;
    logic                        dropped_reg;

    logic                        handshake;
    logic                        final_hs;
    logic                        load_first;
    logic                        advance;
    logic [IDX_W-1:0]            elem_next;
    logic [LOG2_MAX_N-1:0]       row_next;
    logic [LOG2_MAX_N-1:0]       col_next;
    logic signed [ACC_WIDTH-1:0] sel_acc;
    logic [SHIFT_WIDTH-1:0]      sel_shift;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]        quant;
    logic                        quant_sat;

    // Snapshot: one register per element, loaded in parallel on capture.
    // No reset needed; contents are only read while a capture is active.
    generate
        for (genvar gi = 0; gi < ELEMS; gi++) begin : g_snap
            assign acc_arr[gi] = acc_in[ACC_WIDTH*gi +: ACC_WIDTH];

            always_ff @(posedge clk) begin
                if (load_first) begin
                    snap_reg[gi] <= acc_arr[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        handshake  = out_valid_reg && out_ready;
        final_hs   = handshake && out_last_reg;
        // Capture in IDLE, or on the final beat so back-to-back matrices
        // stream without a bubble.
        load_first = acc_valid && ((state_reg == IDLE) || final_hs);
        advance    = handshake && !out_last_reg;

        elem_next = elem_reg + 1'b1;
        row_next  = row_reg;
        col_next  = col_reg + 1'b1;
        if (col_reg == LAST_RC) begin
            col_next = '0;
            row_next = row_reg + 1'b1;
        end

        // On capture the snapshot is not loaded yet, so element (0,0) and
        // its shift come straight from the inputs.
        sel_acc   = load_first ? acc_arr[0] : snap_reg[elem_next];
        sel_shift = load_first ? shift : shift_reg;

        // >>> on a signed operand fills with the sign bit, so shifts of
        // ACC_WIDTH or more naturally give 0 or -1.
        shifted   = sel_acc >>> sel_shift;
        quant     = shifted[OUT_WIDTH-1:0];
        quant_sat = 1'b0;
        if (shifted > SAT_MAX) begin
            quant     = OUT_WIDTH'(SAT_MAX);
            quant_sat = 1'b1;
        end else if (shifted < SAT_MIN) begin
            quant     = OUT_WIDTH'(SAT_MIN);
            quant_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            elem_reg      <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            sat_reg       <= 1'b0;
            dropped_reg   <= 1'b0;
        end else begin
            if (acc_valid && (state_reg == STREAM) && !final_hs) begin
                dropped_reg <= 1'b1;
            end

            if (load_first) begin
                state_reg     <= STREAM;
                shift_reg     <= shift;
                elem_reg      <= '0;
                row_reg       <= '0;
                col_reg       <= '0;
                out_data_reg  <= quant;
                out_last_reg  <= (N == 1);
                out_valid_reg <= 1'b1;
                busy_reg      <= 1'b1;
                sat_reg       <= quant_sat;
            end else if (advance) begin
                elem_reg     <= elem_next;
                row_reg      <= row_next;
                col_reg      <= col_next;
                out_data_reg <= quant;
                out_last_reg <= (row_next == LAST_RC) && (col_next == LAST_RC);
                sat_reg      <= sat_reg | quant_sat;
            end else if (final_hs) begin
                state_reg     <= IDLE;
                out_last_reg  <= 1'b0;
                out_valid_reg <= 1'b0;
                busy_reg      <= 1'b0;
            end
        end
    end

    assign busy      = busy_reg;
    assign out_data  = out_data_reg;
    assign out_row   = row_reg;
    assign out_col   = col_reg;
    assign out_last  = out_last_reg;
    assign out_valid = out_valid_reg;
    assign sat_flag  = sat_reg;
    assign dropped   = dropped_reg;

endmodule

// File: tb/tb_systolic_result_drain.sv
// ---------------------------------------------------------------------------
// tb_systolic_result_drain
//
// Self-checking bench. A queue-based model holds the beats still owed for
// the current matrix (computed with plain 64-bit arithmetic at capture) and
// is compared against every DUT output on every cycle. Directed scenarios
// are followed by a randomized phase; a few literal expectations pin the
// model itself.
// ---------------------------------------------------------------------------
module tb_systolic_result_drain;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int LW = 8;
    localparam int SW = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [N*N*AW-1:0]   acc_in;
    logic                acc_valid;
    logic [SW-1:0]       shift;
    logic                busy;
    logic [OW-1:0]       out_data;
    logic [LW-1:0]       out_row;
    logic [LW-1:0]       out_col;
    logic                out_last;
    logic                out_valid;
    logic                out_ready;
    logic                sat_flag;
    logic                dropped;

    systolic_result_drain #(
        .N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .LOG2_MAX_N(LW), .SHIFT_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset), .acc_in(acc_in), .acc_valid(acc_valid),
        .shift(shift), .busy(busy), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .sat_flag(sat_flag), .dropped(dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int r;
        int c;
        bit last;
        bit sat;
    } beat_t;

    beat_t q[$];
    bit    m_dropped;
    bit    m_sat;
    int    checks;
    int    errors;

    function automatic logic [N*N*AW-1:0] mk(input int a0, input int a1, input int a2, input int a3);
        logic [N*N*AW-1:0] v;
        v[0*AW +: AW] = a0;
        v[1*AW +: AW] = a1;
        v[2*AW +: AW] = a2;
        v[3*AW +: AW] = a3;
        return v;
    endfunction

    // Expected beats of a whole matrix: shift, clamp, running OR of saturation.
    task automatic build(input logic [N*N*AW-1:0] a, input int sh);
        bit cum;
        cum = 0;
        q.delete();
        for (int e = 0; e < N * N; e++) begin
            longint v;
            longint t;
            bit     s;
            beat_t  b;
            v = longint'($signed(a[AW*e +: AW]));
            t = v >>> sh;
            s = 0;
            if (t > 127) begin t = 127; s = 1; end
            else if (t < -128) begin t = -128; s = 1; end
            cum    = cum | s;
            b.d    = int'(t);
            b.r    = e / N;
            b.c    = e % N;
            b.last = (e == N * N - 1);
            b.sat  = cum;
            q.push_back(b);
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", longint'(out_valid), longint'(q.size() > 0));
        chk("busy", longint'(busy), longint'(q.size() > 0));
        chk("dropped", longint'(dropped), longint'(m_dropped));
        chk("sat_flag", longint'(sat_flag), longint'(m_sat));
        if (q.size() > 0) begin
            chk("out_data", longint'($signed(out_data)), longint'(q[0].d));
            chk("out_row", longint'(out_row), longint'(q[0].r));
            chk("out_col", longint'(out_col), longint'(q[0].c));
            chk("out_last", longint'(out_last), longint'(q[0].last));
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, check.
    task automatic step(input bit rst, input bit av, input logic [N*N*AW-1:0] data,
                        input int sh, input bit rdy);
        bit busy0;
        bit hs;
        bit fin;
        reset     = rst;
        acc_valid = av;
        acc_in    = data;
        shift     = SW'(sh);
        out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_dropped = 0;
            m_sat     = 0;
        end else begin
            busy0 = q.size() > 0;
            hs    = busy0 && rdy;
            fin   = hs && (q.size() == 1);
            if (hs)
                $display("beat row=%0d col=%0d data=%0d last=%0d", q[0].r, q[0].c, q[0].d, q[0].last);
            if (av && (!busy0 || fin)) begin
                build(data, sh);
            end else begin
                if (av) m_dropped = 1;
                if (hs) void'(q.pop_front());
            end
            if (q.size() > 0) m_sat = q[0].sat;
        end
        @(negedge clk);
        check_outputs();
    endtask

    logic [N*N*AW-1:0] m1234;
    logic [N*N*AW-1:0] m5678;
    logic [N*N*AW-1:0] msat;
    logic [N*N*AW-1:0] rnd;
    bit                bp_ready [7];

    initial begin
        checks    = 0;
        errors    = 0;
        m_dropped = 0;
        m_sat     = 0;
        m1234 = mk(1, 2, 3, 4);
        m5678 = mk(5, 6, 7, 8);
        msat  = mk(32'h0000_0100, 32'hFFFF_FF00, 32'h0000_1000, 32'h8000_0000);
        bp_ready = '{0, 0, 1, 0, 1, 1, 1};

        // Reset state
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        chk("reset_out_data", longint'(out_data), 0);
        chk("reset_out_row", longint'(out_row), 0);
        chk("reset_out_last", longint'(out_last), 0);

        // Basic drain
        step(0, 1, m1234, 0, 1);
        chk("lit_first_beat", longint'($signed(out_data)), 1);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        chk("lit_last_beat", longint'($signed(out_data)), 4);
        chk("lit_last_flag", longint'(out_last), 1);
        step(0, 0, '0, 0, 1);
        chk("lit_busy_after", longint'(busy), 0);

        // Backpressure
        step(0, 1, m1234, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, '0, 0, bp_ready[i]);
        chk("lit_bp_done", longint'(out_valid), 0);

        // Requantize / saturate
        step(0, 1, msat, 4, 1);
        chk("lit_q16", longint'($signed(out_data)), 16);
        step(0, 0, '0, 0, 1);
        chk("lit_qm16", longint'($signed(out_data)), -16);
        chk("lit_sat_clear", longint'(sat_flag), 0);
        step(0, 0, '0, 0, 1);
        chk("lit_q127", longint'($signed(out_data)), 127);
        chk("lit_sat_set", longint'(sat_flag), 1);
        step(0, 0, '0, 0, 1);
        chk("lit_qm128", longint'($signed(out_data)), -128);
        step(0, 0, '0, 0, 1);
        chk("lit_sat_sticky", longint'(sat_flag), 1);
        step(0, 1, m1234, 0, 1);
        chk("lit_sat_recapture", longint'(sat_flag), 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1);

        // Back-to-back
        step(0, 1, m1234, 0, 1);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        step(0, 1, m5678, 0, 1);
        chk("lit_b2b_first", longint'($signed(out_data)), 5);
        chk("lit_b2b_dropped", longint'(dropped), 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1);

        // Overrun
        step(0, 1, m1234, 0, 1);
        step(0, 1, m5678, 0, 1);
        step(0, 0, '0, 0, 1);
        chk("lit_overrun_data", longint'($signed(out_data)), 3);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1);
        chk("lit_dropped_sticky", longint'(dropped), 1);

        // Reset mid-stream
        step(0, 1, m1234, 0, 1);
        step(0, 0, '0, 0, 1);
        step(1, 0, '0, 0, 1);
        chk("lit_rst_valid", longint'(out_valid), 0);
        chk("lit_rst_dropped", longint'(dropped), 0);
        step(0, 1, m5678, 0, 1);
        chk("lit_restart_row", longint'(out_row), 0);
        chk("lit_restart_data", longint'($signed(out_data)), 5);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1);

        // Randomized phase
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int e = 0; e < N * N; e++) begin
                if ($urandom_range(0, 1) == 1)
                    rnd[AW*e +: AW] = $urandom;
                else
                    rnd[AW*e +: AW] = AW'(int'($urandom_range(0, 4095)) - 2048);
            end
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) == 0,
                 rnd,
                 int'($urandom_range(0, 31)),
                 $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Output side of the systolic matrix multiplier.
- Snapshots the N*N signed accumulator array from the MAC grid when the multiplier signals completion.
- Requantizes each ACC_WIDTH accumulator to OUT_WIDTH with an arithmetic right shift and saturation.
- Streams the results row-major over a valid/ready interface, so the MAC grid can be reset and reloaded while results drain.

Parameters:
- N, 2, matrix dimension (rows = cols); 1..256.
- ACC_WIDTH, 32, width of each signed accumulator.
- OUT_WIDTH, 8, width of each signed output element.
- LOG2_MAX_N, 8, width of the row/col index outputs.
- SHIFT_WIDTH, 5, width of the shift amount; 2**SHIFT_WIDTH >= ACC_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- acc_in  input  N*N*ACC_WIDTH  accumulators; element (r,c) is acc_in[ACC_WIDTH*(r*N+c) +: ACC_WIDTH], two's complement.
- acc_valid  input  1  single-cycle pulse; acc_in is complete this cycle.
- shift  input  SHIFT_WIDTH  right-shift amount, sampled with acc_valid.
- busy  output  1  snapshot held and not yet fully drained.
- out_data  output  OUT_WIDTH  requantized element, signed.
- out_row  output  LOG2_MAX_N  row index of out_data.
- out_col  output  LOG2_MAX_N  column index of out_data.
- out_last  output  1  out_data is element (N-1,N-1).
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  consumer accepts the beat when out_valid is also high.
- sat_flag  output  1  at least one element of the current matrix saturated; sticky until the next capture.
- dropped  output  1  sticky; acc_valid arrived while busy and could not be accepted. Cleared only by reset.

Behaviour:
- Reset: state IDLE; busy=0, out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, sat_flag=0, dropped=0. Reset mid-stream discards the snapshot and drives no further beats.
- State IDLE:
  - acc_valid=1 latches acc_in into an internal N*N*ACC_WIDTH snapshot register and latches shift.
  - Element index is cleared to 0, sat_flag is cleared, and the state goes to STREAM.
  - Next cycle: busy=1 and out_valid=1 with element (0,0).
  - Latency from acc_valid to first out_valid is 1 cycle.
- State STREAM:
  - Outputs are registered and held stable while out_valid=1 and out_ready=0.
  - A handshake (out_valid & out_ready) advances the index row-major: col+1; on col=N-1, col=0 and row+1.
  - The next element is presented the cycle after the handshake, so the drain sustains 1 beat/cycle with out_ready held high.
  - out_last=1 exactly when row=N-1 and col=N-1.
- Final handshake (out_last & out_ready):
  - If acc_valid=0 the same cycle: go to IDLE; the next cycle has out_valid=0, busy=0.
  - If acc_valid=1 the same cycle: capture the new matrix, stay in STREAM, and present element (0,0) of the new matrix the next cycle with no bubble. sat_flag is cleared for the new matrix.
- acc_valid in STREAM other than on the final handshake: ignored, snapshot unchanged, dropped<=1.
- Requantization (combinational from snapshot, result registered into out_data):
  - t = acc >>> shift, arithmetic shift.
  - If t > 2**(OUT_WIDTH-1)-1, output the maximum and set sat_flag.
  - If t < -2**(OUT_WIDTH-1), output the minimum and set sat_flag.
  - Otherwise output t[OUT_WIDTH-1:0].
  - shift >= ACC_WIDTH yields 0 for non-negative acc and -1 for negative acc.
- sat_flag is set on the cycle a saturated element is first presented, not at capture time.
- N=1: the single beat has row=0, col=0, out_last=1.
- Index counters are LOG2_MAX_N wide; upper bits beyond log2(N) stay 0.

Test Plan:
- Basic drain: N=2, shift=0, acc=[(0,0)=1,(0,1)=2,(1,0)=3,(1,1)=4], acc_valid pulse, out_ready=1 -> beats 1,2,3,4 on 4 consecutive cycles starting 1 cycle after the pulse; out_last only on 4; busy falls the cycle after beat 4; sat_flag=0.
- Backpressure: same data, out_ready toggles 0,0,1,0,1,1,1 -> out_data held stable while stalled; beats in order 1,2,3,4 with no duplication or loss.
- Requantize/saturate: shift=4, acc=[0x00000100, 0xFFFFFF00, 0x00001000, 0x80000000] -> out 16, -16, 127 (sat), -128 (sat); sat_flag=1 from beat 3; next capture with in-range data clears it.
- Back-to-back: second acc_valid with data [5,6,7,8] asserted on the same cycle as the final handshake of [1,2,3,4] -> stream 1,2,3,4,5,6,7,8 contiguous; dropped=0.
- Overrun: acc_valid during beat 2 of an ongoing drain -> original matrix drains unchanged; dropped=1 and stays 1 until reset.
- Reset mid-stream: assert reset after beat 1 -> next cycle out_valid=0, busy=0, dropped=0; subsequent acc_valid restarts at (0,0).
